result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Downstream stage of the shared-resource controller; consumes its `out`/`op_valid`/`op_type` stream after BIST releases normal operation.
- Buffers each result with its op type in a small FIFO for readout over a valid/ready interface.
- Keeps per-op-type saturating accumulators and sample counters for on-board sanity checks.

Parameters:
- DATA_W, 16, width of the signed result from the controller.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ACC_W, 24, width of each signed accumulator; must be greater than DATA_W.
- CNT_W, 16, width of each per-type sample counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  normal-mode enable; driven by BIST `enable_normal`.
- in_valid  in  1  controller `op_valid`.
- in_type  in  1  controller `op_type`: 0 = product path, 1 = multiply-accumulate path.
- in_data  in  DATA_W  signed controller result.
- rd_ready  in  1  consumer ready.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_W+1  {type, data} at the FIFO head.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- acc0  out  ACC_W  signed sum of accepted type-0 samples.
- acc1  out  ACC_W  signed sum of accepted type-1 samples.
- cnt0  out  CNT_W  accepted type-0 samples.
- cnt1  out  CNT_W  accepted type-1 samples.
- overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
- state_o  out  2  current state: 0 = IDLE, 1 = COLLECT, 2 = DRAIN.

Behaviour:
- Reset (reset == 0 at a clk edge):
  - state goes to IDLE; FIFO is emptied.
  - All outputs are 0: rd_valid, rd_data, fifo_count, acc0, acc1, cnt0, cnt1, overflow, state_o.
  - Reset overrides any push, pop or transition in the same cycle, including reset asserted mid-stream.
- State machine:
  - IDLE -> COLLECT when enable == 1. On this transition acc0, acc1, cnt0, cnt1 and overflow are cleared; the FIFO is not cleared.
  - COLLECT -> DRAIN when enable == 0.
  - DRAIN -> COLLECT when enable == 1 again. No clear on this transition.
  - DRAIN -> IDLE when the FIFO is empty and enable == 0.
  - Code 3 is illegal; it recovers to IDLE.
- Accept rule: a sample is accepted when state == COLLECT, in_valid == 1, and the FIFO is not full (or a pop happens in the same cycle).
  - In IDLE and DRAIN, in_valid is ignored entirely; no flag is set.
- Drop rule: when state == COLLECT, in_valid == 1, the FIFO is full and there is no simultaneous pop:
  - the sample is dropped;
  - overflow is set to 1 and stays set until reset or the next IDLE->COLLECT transition;
  - counters and accumulators are not updated.
- FIFO:
  - First-word-fall-through; rd_valid = (fifo_count != 0); rd_data is the head entry.
  - Pop occurs when rd_valid && rd_ready.
  - Push and pop in the same cycle leave fifo_count unchanged, including when the FIFO is full.
  - When the FIFO is empty, push and rd_ready in the same cycle perform the push only (no pop).
  - Pointers wrap modulo DEPTH.
  - Latency: a sample accepted at edge N is visible on rd_data/rd_valid after edge N.
- Accumulators (on accept, same edge as the push):
  - in_data is sign-extended to ACC_W+1 and added to acc[in_type].
  - The result saturates to the ACC_W signed range: +(2^(ACC_W-1)-1) or -2^(ACC_W-1). It never wraps.
- Counters: cnt[in_type] increments on accept and saturates at all-ones.
- rd_data and FIFO contents are unaffected by state changes; only reset empties the FIFO.

Optional Feature:
- Macro: RESULT_COLLECTOR_MINMAX_EN.
- When defined, add ports min0, max0, min1, max1 (each out, DATA_W, signed).
  - On the first accepted sample of a type after a clear, both min and max for that type load that sample.
  - After that, they track the running minimum and maximum of accepted samples of that type.
  - They reset to 0 and clear on IDLE->COLLECT, together with the accumulators.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: 3 entries queued in COLLECT, then reset = 0 for 1 cycle.
  -> All outputs 0, state_o = 0, rd_valid = 0 on the next cycle.
- Basic collect: enable = 1, rd_ready = 1 after pushes, push (0,20), (1,22), (0,20).
  -> rd_data sequence 0x00014, 0x10016, 0x00014.
  -> acc0 = 40, acc1 = 22, cnt0 = 2, cnt1 = 1, overflow = 0.
- Overflow: DEPTH = 8, rd_ready = 0, 10 consecutive type-0 pushes of 5.
  -> fifo_count = 8, overflow = 1, cnt0 = 8, acc0 = 40.
  -> With 8 entries queued, one more push with rd_ready = 1 is accepted and fifo_count stays 8.
- Saturation: ACC_W = 24, rd_ready = 1, 258 type-1 pushes of 32767.
  -> acc1 = 8388352 after 256 pushes, then 8388607 (clamped) after 257 and 258 pushes; cnt1 = 258.
  -> A negative run of -32768 clamps at -8388608.
- Drain: 3 entries queued, enable -> 0, in_valid pulsed during DRAIN, rd_ready = 1.
  -> The pulsed samples are ignored; 3 entries are read out; state_o goes 2 -> 0 after the FIFO empties.
- MINMAX_EN: type-0 pushes 20, -7, 13.
  -> min0 = -7, max0 = 20; min1 = 0, max1 = 0 (no type-1 samples).

Source files
------------

// File: rtl/result_collector.sv
// Result collector: FWFT FIFO of {type, data} plus per-type saturating sums and counters.
// Define RESULT_COLLECTOR_MINMAX_EN to add per-type running min/max outputs.
module result_collector #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic                       in_type,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W:0]            rd_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic signed [ACC_W-1:0]    acc0,
  output logic signed [ACC_W-1:0]    acc1,
  output logic [CNT_W-1:0]           cnt0,
  output logic [CNT_W-1:0]           cnt1,
  output logic                       overflow,
  output logic [1:0]                 state_o
`ifdef RESULT_COLLECTOR_MINMAX_EN
  ,
  output logic signed [DATA_W-1:0]   min0,
  output logic signed [DATA_W-1:0]   max0,
  output logic signed [DATA_W-1:0]   min1,
  output logic signed [DATA_W-1:0]   max1
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]           count_q, count_d;
  logic [DATA_W:0]          mem_q [DEPTH];
  logic signed [ACC_W-1:0]  acc0_q, acc0_d, acc1_q, acc1_d;
  logic [CNT_W-1:0]         cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                     ovf_q, ovf_d;
  logic                     empty, full, pop, push, drop, clear;

  // The sum is formed one bit wider so a carry into the sign is visible as overflow.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign pop   = !empty && rd_ready;
  assign push  = (state_q == S_COLLECT) && in_valid && (!full || pop);
  assign drop  = (state_q == S_COLLECT) && in_valid && full && !pop;
  assign clear = (state_q == S_IDLE) && enable;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);

    if (clear) begin
      acc0_d = '0;
      acc1_d = '0;
      cnt0_d = '0;
      cnt1_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (push && !in_type) begin
        acc0_d = sat_add(acc0_q, in_data);
        cnt0_d = sat_inc(cnt0_q);
      end
      if (push && in_type) begin
        acc1_d = sat_add(acc1_q, in_data);
        cnt1_d = sat_inc(cnt1_q);
      end
      if (drop) ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE:    if (enable) state_d = S_COLLECT;
      S_COLLECT: if (!enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (enable)     state_d = S_COLLECT;
        else if (empty) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc0_q   <= '0;
      acc1_q   <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= {in_type, in_data};
  end

`ifdef RESULT_COLLECTOR_MINMAX_EN
  logic                     seen0_q, seen0_d, seen1_q, seen1_d;
  logic signed [DATA_W-1:0] min0_q, min0_d, max0_q, max0_d, min1_q, min1_d, max1_q, max1_d;

  always_comb begin
    seen0_d = seen0_q;
    seen1_d = seen1_q;
    min0_d  = min0_q;
    max0_d  = max0_q;
    min1_d  = min1_q;
    max1_d  = max1_q;
    if (clear) begin
      seen0_d = 1'b0;
      seen1_d = 1'b0;
      min0_d  = '0;
      max0_d  = '0;
      min1_d  = '0;
      max1_d  = '0;
    end else if (push && !in_type) begin
      seen0_d = 1'b1;
      if (!seen0_q || in_data < min0_q) min0_d = in_data;
      if (!seen0_q || in_data > max0_q) max0_d = in_data;
    end else if (push && in_type) begin
      seen1_d = 1'b1;
      if (!seen1_q || in_data < min1_q) min1_d = in_data;
      if (!seen1_q || in_data > max1_q) max1_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seen0_q <= 1'b0;
      seen1_q <= 1'b0;
      min0_q  <= '0;
      max0_q  <= '0;
      min1_q  <= '0;
      max1_q  <= '0;
    end else begin
      seen0_q <= seen0_d;
      seen1_q <= seen1_d;
      min0_q  <= min0_d;
      max0_q  <= max0_d;
      min1_q  <= min1_d;
      max1_q  <= max1_d;
    end
  end

  assign min0 = min0_q;
  assign max0 = max0_q;
  assign min1 = min1_q;
  assign max1 = max1_q;
`endif

  // Head is forced to zero while empty so stale storage never shows after reset.
  assign rd_valid   = !empty;
  assign rd_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign acc0       = acc0_q;
  assign acc1       = acc1_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;
  assign overflow   = ovf_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: vector table, directed corner sequences, random run vs. queue model.
module tb_result_collector;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 16;
  localparam longint ACC_HI = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint ACC_LO = -(longint'(1) << (ACC_W-1));
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset, enable, in_valid, in_type, rd_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     rd_valid;
  logic [DATA_W:0]          rd_data;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic signed [ACC_W-1:0]  acc0, acc1;
  logic [CNT_W-1:0]         cnt0, cnt1;
  logic                     overflow;
  logic [1:0]               state_o;
`ifdef RESULT_COLLECTOR_MINMAX_EN
  logic signed [DATA_W-1:0] min0, max0, min1, max1;
`endif

  result_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_type(in_type),
    .in_data(in_data), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_count(fifo_count), .acc0(acc0), .acc1(acc1), .cnt0(cnt0), .cnt1(cnt1),
    .overflow(overflow), .state_o(state_o)
`ifdef RESULT_COLLECTOR_MINMAX_EN
    , .min0(min0), .max0(max0), .min1(min1), .max1(max1)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: state code, a queue of {type, data}, and plain integer sums.
  int              m_st;
  logic [DATA_W:0] m_q[$];
  longint          m_acc[2];
  int              m_cnt[2];
  bit              m_ovf;
  longint          m_min[2], m_max[2];
  bit              m_seen[2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > ACC_HI) return ACC_HI;
    if (v < ACC_LO) return ACC_LO;
    return v;
  endfunction

  task automatic model_clear_stats();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_min[k] = 0; m_max[k] = 0; m_seen[k] = 0;
    end
    m_ovf = 0;
  endtask

  task automatic model_step(input int r, input int en, input int v, input int t, input int d,
                            input int rr);
    int n;
    bit pop, take;
    if (r == 0) begin
      m_st = 0;
      m_q.delete();
      model_clear_stats();
      return;
    end
    n    = m_q.size();
    pop  = (n > 0) && (rr != 0);
    take = (m_st == 1) && (v != 0) && (n < DEPTH || pop);
    if (pop) void'(m_q.pop_front());
    if (take) begin
      m_q.push_back({t[0], 16'(d)});
      m_acc[t] = clamp(m_acc[t] + d);
      if (m_cnt[t] < CNT_MAX) m_cnt[t]++;
      if (!m_seen[t] || d < m_min[t]) m_min[t] = d;
      if (!m_seen[t] || d > m_max[t]) m_max[t] = d;
      m_seen[t] = 1;
    end
    if (m_st == 1 && v != 0 && n == DEPTH && !pop) m_ovf = 1;
    if (m_st == 0) begin
      if (en != 0) begin m_st = 1; model_clear_stats(); end
    end else if (m_st == 1) begin
      if (en == 0) m_st = 2;
    end else begin
      if (en != 0) m_st = 1;
      else if (n == 0) m_st = 0;
    end
  endtask

  task automatic check_model();
    longint head;
    head = 0;
    if (m_q.size() > 0) head = m_q[0];
    chk("state_o", state_o, m_st);
    chk("fifo_count", fifo_count, m_q.size());
    chk("rd_valid", rd_valid, m_q.size() > 0);
    chk("rd_data", rd_data, head);
    chk("acc0", acc0, m_acc[0]);
    chk("acc1", acc1, m_acc[1]);
    chk("cnt0", cnt0, m_cnt[0]);
    chk("cnt1", cnt1, m_cnt[1]);
    chk("overflow", overflow, m_ovf);
`ifdef RESULT_COLLECTOR_MINMAX_EN
    chk("min0", min0, m_min[0]);
    chk("max0", max0, m_max[0]);
    chk("min1", min1, m_min[1]);
    chk("max1", max1, m_max[1]);
`endif
  endtask

  // Inputs are applied at one rising edge; outputs are sampled 1 time unit after it.
  task automatic apply(input int r, input int en, input int v, input int t, input int d,
                       input int rr);
    reset    = r[0];
    enable   = en[0];
    in_valid = v[0];
    in_type  = t[0];
    in_data  = 16'(d);
    rd_ready = rr[0];
    model_step(r, en, v, t, d, rr);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    int r, en, v, t, d, rr;
    int st, cnt;
    longint rdd, a0, a1;
    int c0, c1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int en_r;
    logic signed [DATA_W-1:0] rd16;
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_type = 1'b0; in_data = '0; rd_ready = 1'b0;
    m_st = 0;
    model_clear_stats();

    // Basic collect then drain back to idle.
    tbl[0] = '{0, 0, 0, 0, 0,  0, 0, 0, 'h00000,  0,  0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0,  0, 1, 0, 'h00000,  0,  0, 0, 0};
    tbl[2] = '{1, 1, 1, 0, 20, 0, 1, 1, 'h00014, 20,  0, 1, 0};
    tbl[3] = '{1, 1, 1, 1, 22, 0, 1, 2, 'h00014, 20, 22, 1, 1};
    tbl[4] = '{1, 1, 1, 0, 20, 0, 1, 3, 'h00014, 40, 22, 2, 1};
    tbl[5] = '{1, 1, 0, 0, 0,  1, 1, 2, 'h10016, 40, 22, 2, 1};
    tbl[6] = '{1, 1, 0, 0, 0,  1, 1, 1, 'h00014, 40, 22, 2, 1};
    tbl[7] = '{1, 1, 0, 0, 0,  1, 1, 0, 'h00000, 40, 22, 2, 1};
    tbl[8] = '{1, 0, 0, 0, 0,  0, 2, 0, 'h00000, 40, 22, 2, 1};
    tbl[9] = '{1, 0, 0, 0, 0,  0, 0, 0, 'h00000, 40, 22, 2, 1};
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].en, tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].rr);
      chk("tbl_state", state_o, tbl[i].st);
      chk("tbl_count", fifo_count, tbl[i].cnt);
      chk("tbl_rd_data", rd_data, tbl[i].rdd);
      chk("tbl_acc0", acc0, tbl[i].a0);
      chk("tbl_acc1", acc1, tbl[i].a1);
      chk("tbl_cnt0", cnt0, tbl[i].c0);
      chk("tbl_cnt1", cnt1, tbl[i].c1);
      chk("tbl_overflow", overflow, 0);
    end

    // Reset in the middle of a stream, with push and pop also requested.
    apply(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(1, 1, 1, i % 2, 100 + i, 0);
    chk("mid_count_before", fifo_count, 3);
    apply(0, 1, 1, 0, 7, 1);
    chk("rst_state", state_o, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_acc0", acc0, 0);
    chk("rst_cnt0", cnt0, 0);

    // Overflow: ten pushes into an eight-deep FIFO with no reads.
    apply(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) apply(1, 1, 1, 0, 5, 0);
    chk("ovf_count", fifo_count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_cnt0", cnt0, 8);
    chk("ovf_acc0", acc0, 40);
    apply(1, 1, 1, 0, 5, 1);
    chk("full_pushpop_count", fifo_count, 8);
    chk("full_pushpop_cnt0", cnt0, 9);
    chk("full_pushpop_acc0", acc0, 45);
    chk("ovf_sticky", overflow, 1);
    apply(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(1, 0, 0, 0, 0, 1);
    chk("drain_hold_state", state_o, 2);
    apply(1, 0, 0, 0, 0, 0);
    chk("drain_to_idle", state_o, 0);
    apply(1, 1, 0, 0, 0, 0);
    chk("restart_ovf_clear", overflow, 0);
    chk("restart_acc0_clear", acc0, 0);

    // Drain: samples offered during DRAIN are ignored.
    for (int i = 0; i < 3; i++) apply(1, 1, 1, 1, -3 - i, 0);
    apply(1, 0, 0, 0, 0, 0);
    chk("drain_state", state_o, 2);
    apply(1, 0, 1, 1, 99, 0);
    chk("drain_ignore_count", fifo_count, 3);
    chk("drain_ignore_cnt1", cnt1, 3);
    chk("drain_no_ovf", overflow, 0);
    for (int i = 0; i < 3; i++) apply(1, 0, 1, 0, 55, 1);
    chk("drain_empty", fifo_count, 0);
    chk("drain_still", state_o, 2);
    apply(1, 0, 0, 0, 0, 1);
    chk("drain_idle", state_o, 0);

    // Saturation of the type-1 accumulator in both directions.
    apply(1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 258; i++) begin
      apply(1, 1, 1, 1, 32767, 1);
      if (i == 256) chk("sat_256", acc1, 8388352);
      if (i == 257) chk("sat_257", acc1, 8388607);
    end
    chk("sat_258", acc1, 8388607);
    chk("sat_cnt1", cnt1, 258);
    for (int i = 0; i < 520; i++) apply(1, 1, 1, 1, -32768, 1);
    chk("sat_neg", acc1, -8388608);
    chk("sat_neg_cnt1", cnt1, 778);

`ifdef RESULT_COLLECTOR_MINMAX_EN
    apply(0, 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 20, 0);
    apply(1, 1, 1, 0, -7, 0);
    apply(1, 1, 1, 0, 13, 0);
    chk("mm_min0", min0, -7);
    chk("mm_max0", max0, 20);
    chk("mm_min1", min1, 0);
    chk("mm_max1", max1, 0);
`endif

    // Random traffic against the model.
    apply(0, 0, 0, 0, 0, 0);
    en_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en_r = 1 - en_r;
      if ($urandom_range(0, 7) == 0) rd16 = $urandom_range(0, 1) ? 16'sh7fff : 16'sh8000;
      else rd16 = 16'($urandom);
      apply(($urandom_range(0, 199) != 0) ? 1 : 0, en_r, ($urandom_range(0, 3) != 0) ? 1 : 0,
            int'($urandom_range(0, 1)), int'(rd16), ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
